// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin owner selection for the shared LED bank.
// A grant is held for at least HOLD_TICKS slow ticks before another requester
// may preempt it; an owner dropping its request releases immediately, and a
// dead IDLE cycle follows every release.
module led_share_arbiter #(
  parameter int                N_REQ        = 4,
  parameter int                LED_W        = 5,
  parameter int                HOLD_TICKS   = 8,
  parameter logic [LED_W-1:0]  DEFAULT_LEDS = {LED_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     tick,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LED_W-1:0]   req_leds,
  output logic [N_REQ-1:0]         grant,
  output logic [LED_W-1:0]         leds,
  output logic                     busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TICKS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [LED_W-1:0]   leds_q,  leds_d;
  logic               busy_q,  busy_d;
  logic [PTR_W-1:0]   ptr_q,   ptr_d;
  logic [CNT_W-1:0]   hold_q,  hold_d;

  logic [PTR_W-1:0]   owner_s;
  logic [N_REQ-1:0]   other_req_s;
  logic [PTR_W-1:0]   win_any_s;
  logic [PTR_W-1:0]   win_other_s;

  // First candidate at or above start, wrapping modulo N_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] cand,
                                               input logic [PTR_W-1:0] start);
    logic [PTR_W-1:0] win;
    logic             found;
    int               idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [PTR_W-1:0] oh_encode(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (oh[k]) begin
        idx = PTR_W'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // One-hot vector with only bit idx set.
  function automatic logic [N_REQ-1:0] oh_decode(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    for (int k = 0; k < N_REQ; k++) begin
      oh[k] = (idx == PTR_W'(k));
    end
    return oh;
  endfunction

  // Requester idx's slice of the pattern bus; other slices never leak out.
  function automatic logic [LED_W-1:0] pat_of(input logic [N_REQ*LED_W-1:0] bus,
                                              input logic [PTR_W-1:0] idx);
    logic [LED_W-1:0] pat;
    pat = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (idx == PTR_W'(k)) begin
        pat = bus[k*LED_W +: LED_W];
      end else begin
        pat = pat;
      end
    end
    return pat;
  endfunction

  // Pointer moves just past the winner so it has lowest priority next time.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] w);
    return (w == LAST_IDX) ? '0 : (w + PTR_W'(1));
  endfunction

  assign owner_s     = oh_encode(grant_q);
  assign other_req_s = req & ~grant_q;
  assign win_any_s   = rr_pick(req, ptr_q);
  assign win_other_s = rr_pick(other_req_s, ptr_q);

  // Next-state and next-output logic: release beats preempt beats hold/refresh.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    leds_d  = leds_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          grant_d = oh_decode(win_any_s);
          leds_d  = pat_of(req_leds, win_any_s);
          busy_d  = 1'b1;
          hold_d  = '0;
          ptr_d   = ptr_after(win_any_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!(|(req & grant_q))) begin
          state_d = ST_IDLE;
          grant_d = '0;
          leds_d  = DEFAULT_LEDS;
          busy_d  = 1'b0;
        end else if ((hold_q == HOLD_MAX) && (|other_req_s)) begin
          grant_d = oh_decode(win_other_s);
          leds_d  = pat_of(req_leds, win_other_s);
          hold_d  = '0;
          ptr_d   = ptr_after(win_other_s);
        end else begin
          leds_d = pat_of(req_leds, owner_s);
          if (tick && (hold_q < HOLD_MAX)) begin
            hold_d = hold_q + CNT_W'(1);
          end else begin
            hold_d = hold_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        leds_d  = DEFAULT_LEDS;
        busy_d  = 1'b0;
        ptr_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      leds_q  <= DEFAULT_LEDS;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant = grant_q;
  assign leds  = leds_q;
  assign busy  = busy_q;

endmodule
